// File: rtl/rtc_bus_responder.sv
// RTC chip side of the multiplexed address/data bus: register file,
// read-latency FSM and free-running BCD time/date counters.
module rtc_bus_responder #(
  parameter int TICK_DIV = 100000000,
  parameter int READ_LAT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ChipSelect,
  input  logic       Write,
  input  logic       Read,
  input  logic       AoD,
  inout  wire  [7:0] DATA_ADDRESS,
  output logic       sec_tick
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int LW = $clog2(READ_LAT) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DRIVE
  } state_t;

  state_t          state, state_n;
  logic [LW-1:0]   cnt, cnt_n;
  logic            snap_ld;
  logic [7:0]      snap;
  logic [PW-1:0]   presc;
  logic            tick;
  logic            cs_q, wr_q, aod_q, err_q;
  logic [7:0]      data_q, addr_q;
  logic [7:0]      sec, min, hour, day, month, year;
  logic [8:0]      s_n, m_n, h_n, d_n, mo_n, y_n;
  logic [7:0]      rd_val;
  logic            commit;

  // Returns {carry, next}; anything at or above hi wraps to lo.
  function automatic logic [8:0] bcd_inc(input logic [7:0] v,
                                         input logic [7:0] hi,
                                         input logic [7:0] lo);
    if (v >= hi)
      return {1'b1, lo};
    else if (v[3:0] >= 4'd9)
      return {1'b0, v[7:4] + 4'd1, 4'd0};
    else
      return {1'b0, v + 8'd1};
  endfunction

  function automatic logic [7:0] mlen(input logic [7:0] mo,
                                      input logic [7:0] yr);
    logic leap;
    leap = yr[4] ? (yr[3:0] == 4'd2 || yr[3:0] == 4'd6)
                 : (yr[3:0] == 4'd0 || yr[3:0] == 4'd4 ||
                    yr[3:0] == 4'd8);
    case (mo)
      8'h02:                      return leap ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
      default:                    return 8'h31;
    endcase
  endfunction

  assign tick = (presc == PW'(TICK_DIV - 1));

  always_comb begin
    s_n  = tick   ? bcd_inc(sec, 8'h59, 8'h00) : {1'b0, sec};
    m_n  = s_n[8] ? bcd_inc(min, 8'h59, 8'h00) : {1'b0, min};
    h_n  = m_n[8] ? bcd_inc(hour, 8'h23, 8'h00) : {1'b0, hour};
    d_n  = h_n[8] ? bcd_inc(day, mlen(month, year), 8'h01)
                  : {1'b0, day};
    mo_n = d_n[8] ? bcd_inc(month, 8'h12, 8'h01) : {1'b0, month};
    y_n  = mo_n[8] ? bcd_inc(year, 8'h99, 8'h00) : {1'b0, year};
  end

  always_comb begin
    rd_val = 8'h00;
    case (addr_q)
      8'h21:   rd_val = sec;
      8'h22:   rd_val = min;
      8'h23:   rd_val = hour;
      8'h24:   rd_val = day;
      8'h25:   rd_val = month;
      8'h26:   rd_val = year;
      default: rd_val = 8'h00;
    endcase
  end

  // Rising Write after a low phase that never overlapped a low Read.
  assign commit = !cs_q && !wr_q && Write && !err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      presc    <= '0;
      sec_tick <= 1'b0;
      cs_q     <= 1'b1;
      wr_q     <= 1'b1;
      aod_q    <= 1'b0;
      err_q    <= 1'b0;
      data_q   <= 8'h00;
      addr_q   <= 8'h00;
      sec      <= 8'h00;
      min      <= 8'h00;
      hour     <= 8'h00;
      day      <= 8'h01;
      month    <= 8'h01;
      year     <= 8'h00;
    end else begin
      presc    <= tick ? '0 : presc + PW'(1);
      sec_tick <= tick;
      cs_q     <= ChipSelect;
      wr_q     <= Write;
      if (!Write) begin
        data_q <= DATA_ADDRESS;
        aod_q  <= AoD;
        err_q  <= (wr_q ? 1'b0 : err_q) | !Read;
      end
      sec   <= s_n[7:0];
      min   <= m_n[7:0];
      hour  <= h_n[7:0];
      day   <= d_n[7:0];
      month <= mo_n[7:0];
      year  <= y_n[7:0];
      if (commit) begin
        if (!aod_q) begin
          addr_q <= data_q;
        end else begin
          case (addr_q)
            8'h21:   sec   <= data_q;
            8'h22:   min   <= data_q;
            8'h23:   hour  <= data_q;
            8'h24:   day   <= data_q;
            8'h25:   month <= data_q;
            8'h26:   year  <= data_q;
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    snap_ld = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!ChipSelect && !Read && Write && AoD) begin
          state_n = S_WAIT;
          cnt_n   = '0;
          snap_ld = 1'b1;
        end
      end
      S_WAIT: begin
        if (ChipSelect || Read || !Write)
          state_n = S_IDLE;
        else if (cnt == LW'(READ_LAT - 1))
          state_n = S_DRIVE;
        else
          cnt_n = cnt + LW'(1);
      end
      S_DRIVE: begin
        if (ChipSelect || Read || !Write)
          state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      snap  <= 8'h00;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (snap_ld)
        snap <= rd_val;
    end
  end

  assign DATA_ADDRESS = (state == S_DRIVE) ? snap : 8'hzz;

endmodule

// File: tb/tb_rtc_bus_responder.sv
// Directed bench for rtc_bus_responder; released bus reads 0xFF
// through pull-ups.
module tb_rtc_bus_responder;

  localparam int TD = 10;
  localparam int RL = 2;

  logic       clk = 1'b0;
  logic       reset, cs, wr, rd, aod, oe;
  logic [7:0] drv;
  logic       tick;
  wire  [7:0] bus;

  int pass_n = 0;
  int total_n = 0;

  assign bus = oe ? drv : 8'hzz;

  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (bus[g]);
  end

  rtc_bus_responder #(
    .TICK_DIV(TD),
    .READ_LAT(RL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ChipSelect  (cs),
    .Write       (wr),
    .Read        (rd),
    .AoD         (aod),
    .DATA_ADDRESS(bus),
    .sec_tick    (tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[10];

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string n, input logic [7:0] act,
                     input logic [7:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %02h want %02h", n, act, exp);
  endtask

  task automatic phase(input logic [7:0] v, input logic a);
    cs = 1'b0; wr = 1'b0; aod = a; drv = v; oe = 1'b1;
    step();
    cs = 1'b1; wr = 1'b1; oe = 1'b0;
    step();
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    phase(a, 1'b0);
    phase(d, 1'b1);
  endtask

  task automatic rd_seq(input string n, input logic [7:0] exp);
    cs = 1'b0; aod = 1'b1; rd = 1'b0;
    step();
    chk({n, " z1"}, bus, 8'hFF);
    step();
    chk({n, " z2"}, bus, 8'hFF);
    step();
    chk({n, " data"}, bus, exp);
    rd = 1'b1; cs = 1'b1;
    step();
    chk({n, " rel"}, bus, 8'hFF);
  endtask

  task automatic rd_chk(input string n, input logic [7:0] a,
                        input logic [7:0] exp);
    phase(a, 1'b0);
    rd_seq(n, exp);
  endtask

  task automatic wait_tick(input string n);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (!tick && k < 3 * TD);
    chk(n, {7'b0, tick}, 8'h01);
  endtask

  task automatic rollover(input logic [7:0] yr, input logic [7:0] eday,
                          input logic [7:0] emon);
    bus_write(8'h21, 8'h00);
    bus_write(8'h26, yr);
    bus_write(8'h25, 8'h02);
    bus_write(8'h24, 8'h28);
    bus_write(8'h23, 8'h23);
    bus_write(8'h22, 8'h59);
    wait_tick("roll sync");
    bus_write(8'h21, 8'h59);
    wait_tick("roll tick");
    rd_chk("roll sec", 8'h21, 8'h00);
    rd_chk("roll min", 8'h22, 8'h00);
    rd_chk("roll hour", 8'h23, 8'h00);
    rd_chk("roll day", 8'h24, eday);
    rd_chk("roll month", 8'h25, emon);
    rd_chk("roll year", 8'h26, yr);
  endtask

  initial begin
    int ticks;
    tbl[0] = '{8'h23, 8'h12, 8'h12};
    tbl[1] = '{8'h24, 8'h15, 8'h15};
    tbl[2] = '{8'h25, 8'h07, 8'h07};
    tbl[3] = '{8'h26, 8'h99, 8'h99};
    tbl[4] = '{8'h22, 8'h34, 8'h34};
    tbl[5] = '{8'h20, 8'hAB, 8'h00};
    tbl[6] = '{8'h27, 8'h11, 8'h00};
    tbl[7] = '{8'h40, 8'h31, 8'h00};
    tbl[8] = '{8'h23, 8'h3A, 8'h3A};
    tbl[9] = '{8'h00, 8'h5A, 8'h00};

    reset = 1'b1; cs = 1'b1; wr = 1'b1; rd = 1'b1;
    aod = 1'b0; oe = 1'b0; drv = 8'h00;
    repeat (3) step();
    chk("reset bus", bus, 8'hFF);
    chk("reset tick", {7'b0, tick}, 8'h00);
    reset = 1'b0;
    rd_chk("reset day", 8'h24, 8'h01);

    for (int i = 0; i < 10; i++) begin
      bus_write(tbl[i].addr, tbl[i].wdata);
      rd_chk($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].exp);
    end

    wait_tick("sec sync");
    bus_write(8'h22, 8'h00);
    bus_write(8'h21, 8'h58);
    ticks = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (tick) ticks++;
    end
    chk("tick count", 8'(ticks), 8'h02);
    rd_chk("sec wrap", 8'h21, 8'h00);
    rd_chk("min carry", 8'h22, 8'h01);

    rollover(8'h24, 8'h29, 8'h02);
    rollover(8'h23, 8'h01, 8'h03);

    bus_write(8'h40, 8'h31);
    rd_chk("unmapped", 8'h40, 8'h00);
    rd_chk("keep min", 8'h22, 8'h00);
    rd_chk("keep hour", 8'h23, 8'h00);
    rd_chk("keep day", 8'h24, 8'h01);
    rd_chk("keep month", 8'h25, 8'h03);
    rd_chk("keep year", 8'h26, 8'h23);

    phase(8'h24, 1'b0);
    cs = 1'b0; aod = 1'b1; rd = 1'b0;
    repeat (3) step();
    chk("pre-rst drive", bus, 8'h01);
    reset = 1'b1;
    step();
    chk("rst release", bus, 8'hFF);
    reset = 1'b0; rd = 1'b1; cs = 1'b1;
    step();
    rd_chk("rst sec", 8'h21, 8'h00);
    rd_chk("rst min", 8'h22, 8'h00);
    rd_chk("rst hour", 8'h23, 8'h00);
    rd_chk("rst day", 8'h24, 8'h01);
    rd_chk("rst month", 8'h25, 8'h01);
    rd_chk("rst year", 8'h26, 8'h00);
    bus_write(8'h26, 8'h77);
    rd_chk("post-rst wr", 8'h26, 8'h77);

    phase(8'h23, 1'b0);
    cs = 1'b0; aod = 1'b1; rd = 1'b0; wr = 1'b0; oe = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("err z%0d", i), bus, 8'hFF);
    end
    rd = 1'b1; wr = 1'b1; cs = 1'b1;
    step();
    chk("err end z", bus, 8'hFF);
    rd_seq("err hour", 8'h00);
    rd_chk("err year", 8'h26, 8'h77);

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
